// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with registered, mutually exclusive grants.
// Define ARB_TIMEOUT_EN to compile in the hold counter and timeout preemption.
module bus_arbiter #(
  parameter int MAX_HOLD  = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic done,
  output logic gnt1,
  output logic gnt2,
  output logic master_select,
  output logic busy,
  output logic preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN1 = 2'b01,
    OWN2 = 2'b10
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_last_m1;      // 1: master1 was served last, 0: master2
  logic   r_sel;
  logic   w_sel_nxt;
  logic   w_last_m1_nxt;
  logic   w_own_req;
  logic   w_other_req;
  logic   w_release;
  logic   w_hold_full;
  logic   w_hold_clr;
  logic   w_timeout;

  assign w_own_req   = (r_state == OWN1) ? req1 : req2;
  assign w_other_req = (r_state == OWN1) ? req2 : req1;
  assign w_release   = done || !w_own_req;
  assign w_timeout   = (r_state != IDLE) && !w_release && w_hold_full && w_other_req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold_clr = 1'b1;
        if (req1 && (!req2 || !r_last_m1)) w_state_nxt = OWN1;
        else if (req2)                     w_state_nxt = OWN2;
      end
      OWN1, OWN2: begin
        if (w_release) begin
          w_hold_clr = 1'b1;
          if (w_other_req)    w_state_nxt = (r_state == OWN1) ? OWN2 : OWN1;
          else if (!w_own_req) w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_hold_clr  = 1'b1;
          w_state_nxt = (r_state == OWN1) ? OWN2 : OWN1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The mux select and the fairness pointer both hold their value through IDLE.
  always_comb begin
    w_sel_nxt     = r_sel;
    w_last_m1_nxt = r_last_m1;
    if (w_state_nxt == OWN1) begin
      w_sel_nxt     = 1'b1;
      w_last_m1_nxt = 1'b1;
    end else if (w_state_nxt == OWN2) begin
      w_sel_nxt     = 1'b0;
      w_last_m1_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b0;
      r_sel     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_last_m1 <= w_last_m1_nxt;
      r_sel     <= w_sel_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  logic [CNT_WIDTH-1:0] r_hold;
  logic                 r_preempt;

  assign w_hold_full = (r_hold == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_timeout;
      if (w_hold_clr)        r_hold <= '0;
      else if (!w_hold_full) r_hold <= r_hold + 1'b1;
    end
  end

  assign preempt = r_preempt;
`else
  logic w_unused_cfg;

  assign w_hold_full  = 1'b0;
  assign w_unused_cfg = ^{w_hold_clr, (MAX_HOLD == CNT_WIDTH)};
  assign preempt      = 1'b0;
`endif

  assign gnt1          = (r_state == OWN1);
  assign gnt2          = (r_state == OWN2);
  assign busy          = (r_state != IDLE);
  assign master_select = r_sel;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter that drives the `master_select` input of the shared master mux/slave decoder.
- Accepts one request line per master and issues mutually exclusive registered grants with round-robin fairness.
- Holds each grant until the owning master finishes its transaction or drops its request.
- Optionally preempts an owner that exceeds a hold budget while the other master waits.
- Sits between the two bus masters and the mux/decoder, replacing the static select line used in bring-up.

## Interface
Parameters:
- `MAX_HOLD`, 8: maximum consecutive owned cycles before preemption (only with timeout feature); legal range 2..2^CNT_WIDTH.
- `CNT_WIDTH`, 4: width of the hold counter.

Ports:
- `clk`  in  1  bus clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req1`  in  1  master1 requests the bus; held high until its transaction completes.
- `req2`  in  1  master2 requests the bus.
- `done`  in  1  single-cycle pulse: current bus transaction complete.
- `gnt1`  out  1  master1 owns the bus.
- `gnt2`  out  1  master2 owns the bus.
- `master_select`  out  1  mux select: 1 = master1, 0 = master2.
- `busy`  out  1  bus currently owned (`gnt1 | gnt2`).
- `preempt`  out  1  one-cycle pulse: owner revoked by timeout.

## Operation
- States:
  - IDLE: no owner.
  - OWN1: master1 owns the bus.
  - OWN2: master2 owns the bus.
- Register `last`: last master served. Reset value is master2, so master1 wins the first tie.
- IDLE:
  - `req1` only -> OWN1.
  - `req2` only -> OWN2.
  - Both -> the master other than `last`.
  - Neither -> stay in IDLE.
- OWN_x release condition: `done` high or `req_x` low. On release:
  - Other master requesting -> OWN_other directly, with no IDLE cycle.
  - Else `req_x` still high -> stay in OWN_x and clear the hold counter.
  - Else -> IDLE.
- Entering OWN_x sets `last` = x and clears the hold counter.
- Hold counter increments every cycle in OWN_x and saturates at `MAX_HOLD`-1.
- Outputs decoded from registered state:
  - `gnt1` = OWN1; `gnt2` = OWN2.
  - `master_select` = 1 in OWN1, 0 in OWN2, holds its last value in IDLE so the mux is stable.
  - `busy` = OWN1 | OWN2.
- `gnt1` and `gnt2` are never high together.
- `done` in IDLE is ignored.
- `done` with both requests low while in OWN_x -> IDLE.
- Reset values: state IDLE, `gnt1`=0, `gnt2`=0, `master_select`=1, `busy`=0, `preempt`=0, counter 0, `last`=master2.
- Reset mid-transaction drops the grant immediately (asynchronous). No transaction is resumed after reset.

## Timing
- Request to grant: 1 cycle. A `req` sampled at edge n gives `gnt` high after edge n.
- Handover: `done` sampled at edge n gives old `gnt` low and new `gnt` high, both after edge n. There is zero dead cycles between owners.
- `master_select` changes on the same edge as the grants.
- Timeout, when compiled in:
  - Condition: in OWN_x with counter == `MAX_HOLD`-1, other master requesting, and no release this cycle.
  - Result: switch to OWN_other on that edge, with `preempt` high for exactly one cycle after the edge.
- `done` and timeout in the same cycle: treated as a normal release; `preempt` stays 0.
- `preempt` is a registered output with reset value 0.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - Hold counter and preemption logic compiled in.
  - Worst-case wait for a requester is `MAX_HOLD` cycles plus 1.
- Undefined:
  - No counter is synthesized; `preempt` is tied to 0.
  - An owner keeps the bus until `done` or until it drops its request.
  - `MAX_HOLD` and `CNT_WIDTH` are ignored.

## Test plan
- Reset: `rst`=0 for 5 cycles with `req1`=`req2`=1 -> `gnt1`=`gnt2`=0, `master_select`=1, `busy`=0; release `rst` -> `gnt1`=1 one cycle later.
- Single requester: `req2`=1 from IDLE -> `gnt2`=1 and `master_select`=0 after 1 edge; `done` pulse with `req2` then low -> IDLE next edge, `master_select` stays 0.
- Round-robin: `req1`=`req2`=1 held, `done` pulsed every 4 cycles -> grants alternate 1,2,1,2 with no idle cycle between owners; never both high.
- Request drop: OWN1 with `req1` cleared and `req2`=1 -> `gnt2`=1 on the next edge without any `done`.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=8): master1 owns, `req2`=1, no `done` -> after 8 owned cycles `gnt2`=1 and `preempt` high for exactly 1 cycle; repeat build without the macro -> master1 keeps the bus indefinitely and `preempt`=0.
- Async reset mid-transaction: assert `rst` low between clock edges while in OWN2 -> `gnt2` and `busy` fall immediately, not at the next edge.
